ysyx_22050039_idu_pipe: RTL
===========================

Name: ysyx_22050039_idu_pipe

Overview:
Second-generation RV64 decode stage: register file, instruction decoder and a pipeline register behind valid/ready handshakes on both sides.
- Scoreboard of pending destination registers stalls RAW/WAW hazards.
- NR_WB independent write-back ports.
- Sits between IFU (in_*) and EXU (out_*); write-back comes from the EXU/LSU side.

Parameters:
XLEN, 64, data/register width
INST_LEN, 32, instruction width
NR_REG, 32, number of GPRs (x0 hardwired 0)
REG_SEL, 5, register index width (log2 NR_REG)
NR_WB, 2, number of write-back ports (1..4)
FUNC_LEN, 4, width of func code

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  IFU has an instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  INST_LEN  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU consumes bundle
out_pc  out  XLEN  PC of bundle
out_src1  out  XLEN  operand 1
out_src2  out  XLEN  operand 2
out_imm  out  XLEN  sign-extended immediate
out_rd  out  REG_SEL  destination index
out_rd_wen  out  1  instruction writes rd
out_func  out  FUNC_LEN  operation code
out_pc_wen  out  1  instruction redirects PC (JAL/JALR)
wb_en  in  NR_WB  per-port write enable
wb_rd  in  NR_WB*REG_SEL  per-port dest index, port k at [k*REG_SEL +: REG_SEL]
wb_data  in  NR_WB*XLEN  per-port data, port k at [k*XLEN +: XLEN]
flush  in  1  kill held bundle
halted  out  1  EBREAK issued; sticky until reset

Behaviour:
- Reset (rst=0, async): all regs, busy[] and halted =0; out_valid=0; all out_* =0.
- func codes: 0 INV, 1 ADDI, 2 JALR, 3 AUIPC, 4 LUI, 5 SD, 6 JAL, 7 EBREAK, 8 ADD, 9 SUB, 10 BEQ, 11 BNE, 12 LD. Opcodes and funct3/funct7 are RV64I standard. Anything else is INV.
- out_rd_wen=1 for ADDI, JALR, AUIPC, LUI, JAL, ADD, SUB, LD; out_pc_wen=1 for JAL, JALR.
- Operand selection:
  - R: src1=x[rs1], src2=x[rs2].
  - I (ADDI/JALR/LD): src1=x[rs1], src2=imm.
  - S/B: src1=x[rs1], src2=x[rs2], imm holds the offset.
  - LUI: src1=imm<<12 sign-extended, src2=0.
  - AUIPC: src1=imm<<12 sign-extended, src2=pc.
  - JAL: src1=pc, src2=J-imm.
  - EBREAK/INV: src1=src2=imm=0.
- Hazard:
  - Sources used: rs1 for R/I/S/B; rs2 for R/S/B.
  - Stall when any used source is busy.
  - Stall when out_rd_wen and busy[rd] (WAW).
  - x0 is never busy.
- Handshakes:
  - in_ready = !halted & !flush & !stall & (!out_valid | out_ready).
  - Accept = in_valid & in_ready. On accept the bundle is registered; out_valid=1 next cycle. Latency is 1 cycle.
  - Output is held stable while out_valid & !out_ready.
  - Consumed without a new accept: out_valid->0.
- Scoreboard:
  - Accept with rd_wen & rd!=0 sets busy[rd].
  - wb_en[k] with wb_rd[k]!=0 writes the reg and clears busy.
  - Same-cycle set and clear of one rd: set wins.
  - Two wb ports hitting the same rd: highest port index wins.
  - Writes to x0 are ignored.
  - Write-back to a non-busy reg is legal.
- Flush:
  - out_valid<=0.
  - If the held bundle has rd_wen & rd!=0, busy[out_rd] is cleared.
  - No accept that cycle.
- EBREAK: on accept, halted<=1. in_ready then stays 0 until reset; the EBREAK bundle still drains normally.
- INV: issued with rd_wen=0, pc_wen=0; busy[] unchanged.

Optional Feature:
Macro YSYX_22050039_WB_BYPASS_EN.
- Defined: a source written by any wb port this cycle is not treated as busy and reads wb_data combinationally, so the dependent instruction is accepted in the same cycle as the write-back.
- Undefined: hazard check uses registered busy[] only, and operands come from the array only. The dependent instruction is accepted one cycle after the write-back.

Test Plan:
1. Reset; in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000 -> next cycle out_valid=1, func=1, src1=0, src2=5, rd=1, rd_wen=1; busy[1]=1.
2. With x1 busy, present 0x00108113 (addi x2,x1,1) -> in_ready=0. Port0 writes x1=5 -> accept in the same cycle with bypass (next cycle without), then out_src1=5, out_src2=1.
3. Hold out_ready=0 for 4 cycles with in_valid=1 -> out_* stable, in_ready=0. Raise out_ready -> next instruction accepted that cycle.
4. Ports 0 and 1 both write x3 with 7 and 9 in the same cycle -> a later add x4,x3,x0 (0x00018233) gives src1=9, src2=0, func=8.
5. Issue 0x00100073 -> func=7, halted=1, in_ready=0 until rst pulses low. Issue 0xFFFFFFFF -> func=0, rd_wen=0, busy unchanged.
6. Hold addi x5 (0x00500293) with out_ready=0, pulse flush -> out_valid=0, busy[5]=0, no accept that cycle.

Source files
------------

// File: rtl/ysyx_22050039_idu_pipe.sv
// RV64 decode stage: register file, decoder, RAW/WAW scoreboard and output register; optional WB bypass via YSYX_22050039_WB_BYPASS_EN.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready drops on hazard, halt, flush or a held bundle that the EXU is not taking.
module ysyx_22050039_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int NR_REG   = 32,
    parameter int REG_SEL  = 5,
    parameter int NR_WB    = 2,
    parameter int FUNC_LEN = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_LEN-1:0]      in_inst,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_src1,
    output logic [XLEN-1:0]          out_src2,
    output logic [XLEN-1:0]          out_imm,
    output logic [REG_SEL-1:0]       out_rd,
    output logic                     out_rd_wen,
    output logic [FUNC_LEN-1:0]      out_func,
    output logic                     out_pc_wen,
    input  logic [NR_WB-1:0]         wb_en,
    input  logic [NR_WB*REG_SEL-1:0] wb_rd,
    input  logic [NR_WB*XLEN-1:0]    wb_data,
    input  logic                     flush,
    output logic                     halted
);

    localparam logic [FUNC_LEN-1:0] F_INV    = FUNC_LEN'(0);
    localparam logic [FUNC_LEN-1:0] F_ADDI   = FUNC_LEN'(1);
    localparam logic [FUNC_LEN-1:0] F_JALR   = FUNC_LEN'(2);
    localparam logic [FUNC_LEN-1:0] F_AUIPC  = FUNC_LEN'(3);
    localparam logic [FUNC_LEN-1:0] F_LUI    = FUNC_LEN'(4);
    localparam logic [FUNC_LEN-1:0] F_SD     = FUNC_LEN'(5);
    localparam logic [FUNC_LEN-1:0] F_JAL    = FUNC_LEN'(6);
    localparam logic [FUNC_LEN-1:0] F_EBREAK = FUNC_LEN'(7);
    localparam logic [FUNC_LEN-1:0] F_ADD    = FUNC_LEN'(8);
    localparam logic [FUNC_LEN-1:0] F_SUB    = FUNC_LEN'(9);
    localparam logic [FUNC_LEN-1:0] F_BEQ    = FUNC_LEN'(10);
    localparam logic [FUNC_LEN-1:0] F_BNE    = FUNC_LEN'(11);
    localparam logic [FUNC_LEN-1:0] F_LD     = FUNC_LEN'(12);

    logic [XLEN-1:0]     regs_q [NR_REG];
    logic [XLEN-1:0]     regs_d [NR_REG];
    logic [NR_REG-1:0]   busy_q, busy_d;
    logic                halted_q, halted_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_pc_q, out_pc_d, out_src1_q, out_src1_d;
    logic [XLEN-1:0]     out_src2_q, out_src2_d, out_imm_q, out_imm_d;
    logic [REG_SEL-1:0]  out_rd_q, out_rd_d;
    logic                out_rd_wen_q, out_rd_wen_d, out_pc_wen_q, out_pc_wen_d;
    logic [FUNC_LEN-1:0] out_func_q, out_func_d;

    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic [REG_SEL-1:0]  rs1, rs2, rd;
    logic [XLEN-1:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [FUNC_LEN-1:0] dec_func;
    logic                dec_rd_wen, dec_pc_wen, use_rs1, use_rs2;
    logic [XLEN-1:0]     dec_imm, dec_src1, dec_src2;
    logic [XLEN-1:0]     rs1_val, rs2_val;
    logic                rs1_hit, rs2_hit, stall, accept;
    logic [REG_SEL-1:0]  wb_rd_a  [NR_WB];
    logic [XLEN-1:0]     wb_dat_a [NR_WB];

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];

    assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        dec_func = F_INV;
        case (opcode)
            7'b0010011: if (funct3 == 3'b000) dec_func = F_ADDI;
            7'b1100111: if (funct3 == 3'b000) dec_func = F_JALR;
            7'b0010111: dec_func = F_AUIPC;
            7'b0110111: dec_func = F_LUI;
            7'b0100011: if (funct3 == 3'b011) dec_func = F_SD;
            7'b1101111: dec_func = F_JAL;
            7'b1110011: if (in_inst == INST_LEN'(32'h0010_0073)) dec_func = F_EBREAK;
            7'b0110011: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) dec_func = F_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_func = F_SUB;
            end
            7'b1100011: begin
                if (funct3 == 3'b000) dec_func = F_BEQ;
                else if (funct3 == 3'b001) dec_func = F_BNE;
            end
            7'b0000011: if (funct3 == 3'b011) dec_func = F_LD;
            default: ;
        endcase
    end

    always_comb begin
        dec_rd_wen = 1'b0;
        dec_pc_wen = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec_imm    = '0;
        case (dec_func)
            F_ADDI, F_LD: begin dec_rd_wen = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i; end
            F_JALR: begin
                dec_rd_wen = 1'b1; dec_pc_wen = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i;
            end
            F_AUIPC, F_LUI: begin dec_rd_wen = 1'b1; dec_imm = imm_u; end
            F_JAL: begin dec_rd_wen = 1'b1; dec_pc_wen = 1'b1; dec_imm = imm_j; end
            F_ADD, F_SUB: begin dec_rd_wen = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            F_SD: begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_s; end
            F_BEQ, F_BNE: begin use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_b; end
            default: ;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NR_WB; k++) begin
            wb_rd_a[k]  = wb_rd[k*REG_SEL +: REG_SEL];
            wb_dat_a[k] = wb_data[k*XLEN +: XLEN];
        end
    end

    // regs_q[0] is never written, so reading it always yields zero
    always_comb begin
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
`ifdef YSYX_22050039_WB_BYPASS_EN
        for (int k = 0; k < NR_WB; k++) begin
            if (wb_en[k] && wb_rd_a[k] != '0) begin
                if (wb_rd_a[k] == rs1) begin rs1_hit = 1'b1; rs1_val = wb_dat_a[k]; end
                if (wb_rd_a[k] == rs2) begin rs2_hit = 1'b1; rs2_val = wb_dat_a[k]; end
            end
        end
`endif
    end

    always_comb begin
        dec_src1 = '0;
        dec_src2 = '0;
        case (dec_func)
            F_ADDI, F_JALR, F_LD: begin dec_src1 = rs1_val; dec_src2 = dec_imm; end
            F_SD, F_BEQ, F_BNE, F_ADD, F_SUB: begin dec_src1 = rs1_val; dec_src2 = rs2_val; end
            F_LUI: dec_src1 = dec_imm;
            F_AUIPC: begin dec_src1 = dec_imm; dec_src2 = in_pc; end
            F_JAL: begin dec_src1 = in_pc; dec_src2 = dec_imm; end
            default: ;
        endcase
    end

    assign stall    = (use_rs1 & busy_q[rs1] & ~rs1_hit) | (use_rs2 & busy_q[rs2] & ~rs2_hit) |
                      (dec_rd_wen & busy_q[rd]);
    assign in_ready = ~halted_q & ~flush & ~stall & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        halted_d     = halted_q | (accept & (dec_func == F_EBREAK));
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_src1_d   = out_src1_q;
        out_src2_d   = out_src2_q;
        out_imm_d    = out_imm_q;
        out_rd_d     = out_rd_q;
        out_rd_wen_d = out_rd_wen_q;
        out_pc_wen_d = out_pc_wen_q;
        out_func_d   = out_func_q;

        // ascending port order lets the highest index win on a shared rd
        for (int k = 0; k < NR_WB; k++) begin
            if (wb_en[k] && wb_rd_a[k] != '0) begin
                regs_d[wb_rd_a[k]] = wb_dat_a[k];
                busy_d[wb_rd_a[k]] = 1'b0;
            end
        end
        if (flush && out_valid_q && out_rd_wen_q && out_rd_q != '0)
            busy_d[out_rd_q] = 1'b0;
        if (accept && dec_rd_wen && rd != '0)
            busy_d[rd] = 1'b1;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_pc_d     = in_pc;
            out_src1_d   = dec_src1;
            out_src2_d   = dec_src2;
            out_imm_d    = dec_imm;
            out_rd_d     = dec_rd_wen ? rd : '0;
            out_rd_wen_d = dec_rd_wen;
            out_pc_wen_d = dec_pc_wen;
            out_func_d   = dec_func;
        end else if (flush || out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) regs_q[i] <= '0;
            busy_q       <= '0;
            halted_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_src1_q   <= '0;
            out_src2_q   <= '0;
            out_imm_q    <= '0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            out_pc_wen_q <= 1'b0;
            out_func_q   <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_src1_q   <= out_src1_d;
            out_src2_q   <= out_src2_d;
            out_imm_q    <= out_imm_d;
            out_rd_q     <= out_rd_d;
            out_rd_wen_q <= out_rd_wen_d;
            out_pc_wen_q <= out_pc_wen_d;
            out_func_q   <= out_func_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_src1   = out_src1_q;
    assign out_src2   = out_src2_q;
    assign out_imm    = out_imm_q;
    assign out_rd     = out_rd_q;
    assign out_rd_wen = out_rd_wen_q;
    assign out_pc_wen = out_pc_wen_q;
    assign out_func   = out_func_q;
    assign halted     = halted_q;

endmodule
